// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int sample_cnt_w(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high serial line; both flops reset to 1.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity/framing/overrun reporting and valid/ack output.
// Optional: define RX_MAJORITY_VOTE_EN for 2-of-3 voting around every sample point.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 tick,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SCW = sample_cnt_w(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [SCW-1:0] HALF_M1   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] FULL_M1   = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic           ODD_PAR   = (PARITY_MODE == PARITY_ODD);

    logic rx_s;
    logic line;

    uart_rx_sync u_sync (
        .clk   (tick),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef RX_MAJORITY_VOTE_EN
    // The vote covers rx_s at t-2, t-1, t, so every decision lands one cycle late.
    logic [1:0] vote_q;

    always_ff @(posedge tick) begin
        if (reset) vote_q <= 2'b11;
        else       vote_q <= {vote_q[0], rx_s};
    end

    assign line = (rx_s & vote_q[0]) | (rx_s & vote_q[1]) | (vote_q[0] & vote_q[1]);
`else
    assign line = rx_s;
`endif

    uart_rx_state_t        state, state_nx;
    logic [SCW-1:0]        sample_cnt, cnt_nx;
    logic [BCW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0]  shreg, sh_nx;
    logic                  perr_acc, perr_nx;
    logic                  ferr_acc, ferr_nx;
    logic                  done;

    always_ff @(posedge tick) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
        end else begin
            state      <= state_nx;
            sample_cnt <= cnt_nx;
            bit_cnt    <= bit_nx;
            shreg      <= sh_nx;
            perr_acc   <= perr_nx;
            ferr_acc   <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = sample_cnt;
        bit_nx   = bit_cnt;
        sh_nx    = shreg;
        perr_nx  = perr_acc;
        ferr_nx  = ferr_acc;
        done     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx  = '0;
                bit_nx  = '0;
                perr_nx = 1'b0;
                ferr_nx = 1'b0;
                if (!line) state_nx = START;
            end
            START: begin
                if (sample_cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    state_nx = line ? IDLE : DATA;
                end else begin
                    cnt_nx = sample_cnt + 1'b1;
                end
            end
            DATA: begin
                if (sample_cnt == FULL_M1) begin
                    cnt_nx = '0;
                    // LSB arrives first, so shift right with new bits entering at the top
                    sh_nx  = {line, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_nx   = '0;
                        state_nx = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = sample_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (sample_cnt == FULL_M1) begin
                    cnt_nx   = '0;
                    perr_nx  = (^shreg) ^ line ^ ODD_PAR;
                    state_nx = STOP;
                end else begin
                    cnt_nx = sample_cnt + 1'b1;
                end
            end
            STOP: begin
                if (sample_cnt == FULL_M1) begin
                    cnt_nx  = '0;
                    ferr_nx = ferr_acc | ~line;
                    if (bit_cnt == LAST_STOP) begin
                        bit_nx   = '0;
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = sample_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output handshake: a completed frame commits only if the slot is free or being freed.
    always_ff @(posedge tick) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done && (!valid || ack)) begin
                data       <= shreg;
                parity_err <= perr_acc;
                frame_err  <= ferr_nx;
                valid      <= 1'b1;
            end else if (valid && ack) begin
                valid <= 1'b0;
            end

            if (done && valid && !ack) overrun <= 1'b1;
            else if (valid && ack)     overrun <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. It adds configurable data width, oversampling ratio, optional parity, one or two stop bits, parity/framing/overrun error reporting, and a valid/ack output handshake. It runs on the oversampling tick clock and feeds a register or FIFO consumer in the same tick domain.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
OVERSAMPLE, 16, tick cycles per bit period, even, legal 8..32.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits expected, 1 or 2.

Ports:
tick  input  1  clock at baud rate × OVERSAMPLE.
reset  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
data  output  DATA_BITS  last received word, held until the next accepted frame.
valid  output  1  data holds an unconsumed word.
ack  input  1  consumer takes the word; meaningful only while valid=1.
parity_err  output  1  parity mismatch on the word in data; always 0 when PARITY_MODE=0.
frame_err  output  1  a stop bit was sampled low on the word in data.
overrun  output  1  sticky; a frame completed while valid=1 and was dropped.
busy  output  1  state ≠ IDLE.

Behaviour:
- One clock, tick. Reset is synchronous and active-high. Port names are tick and reset.
- rx passes through a 2-flop synchroniser to form rx_s. Both flops reset to 1.
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame; no partial word is ever presented.
- Counters: sample_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits; shift register is DATA_BITS wide.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s=0, go to START with sample_cnt=0.
- START: increment sample_cnt. At sample_cnt = OVERSAMPLE/2−1 (mid-bit):
  - rx_s=1: treat as a glitch and return to IDLE.
  - rx_s=0: clear sample_cnt and go to DATA.
- DATA: sample at sample_cnt = OVERSAMPLE−1, one full bit period after the previous sample point.
  - Shift the bit in at the MSB and shift right, so the first bit received ends in bit 0.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else go to STOP.
- PARITY: take one sample. Error = XOR(data bits, parity bit) for even; its inverse for odd.
- STOP: take STOP_BITS samples. Any low sample sets the frame error.
- Completion: on the cycle after the final stop sample (mid stop bit):
  - state returns to IDLE, so back-to-back frames are accepted.
  - The result is committed, subject to the valid handshake below.
- Commit when valid=0, or when valid=1 and ack=1 in the same cycle:
  - data, parity_err and frame_err load together.
  - valid=1 on the next cycle.
  - No overrun.
- Drop when valid=1 and ack=0: data and both error flags are unchanged; overrun is set.
- ack with valid=1 and no completion in that cycle: valid→0 next cycle. data and the error flags hold their values.
- overrun clears only on ack or reset. If a new overrun occurs in the same cycle as an ack, overrun stays 1.
- ack while valid=0 is ignored.
- Line latency: the falling start edge on rx reaches rx_s 2 cycles later. valid rises 1 cycle after the last stop-bit sample.
- No break detection. An all-zero frame with a low stop bit is a frame error only.

Optional Feature:
RX_MAJORITY_VOTE_EN.
- Defined: every bit decision, including the start check, is a 2-of-3 vote of rx_s at sample points −1, 0 and +1 around the nominal point. Adds 2 vote flops; the +1 sample delays each decision and valid by 1 cycle.
- Undefined: single sample at the nominal point, as described above.

Decomposition:
- Package uart_pkg holds:
  - state enum uart_rx_state_t;
  - parity constants PARITY_NONE/EVEN/ODD;
  - a function computing sample_cnt width from OVERSAMPLE.
- One sub-module: uart_rx_sync, the 2-flop synchroniser with reset-to-1. It is reusable by the future transmitter loopback.
- The rest of the design is a single FSM module.

Test Plan:
1. 8N1, OVERSAMPLE=16: send 0xA5 → data=0xA5, valid=1, both error flags 0; ack → valid=0 next cycle.
2. rx low for 5 ticks then high → no valid; busy returns to 0 within OVERSAMPLE/2+2 cycles.
3. PARITY_MODE=1: send 0x37 with parity bit 0 (correct is 1) → data=0x37, parity_err=1. Repeat with parity bit 1 → parity_err=0.
4. STOP_BITS=2: send 0x5A with the second stop bit low → data=0x5A, frame_err=1, valid=1.
5. Two back-to-back frames 0x11 and 0x22 with no ack → data=0x11, overrun=1. Then ack → valid=0, overrun=0. Repeat with ack on the completion cycle of 0x22 → data=0x22, valid=1, overrun=0.
6. Assert reset for 1 cycle mid-DATA of 0xFF, then send 0x0F → only 0x0F is presented, with no stale bits.
